// File: rtl/piano_pkg.sv
// Shared definitions for the piano auto-play path: FSM state codes,
// song ROM field layout, tempo unit table and LED decode.
`timescale 1ns/1ps
package piano_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Song ROM word layout: {note[9:6], octave[5:4], dur[3:0]}
    localparam int NOTE_MSB = 9;
    localparam int OCT_MSB  = 5;
    localparam int DUR_MSB  = 3;

    // Note code that means silence
    localparam logic [3:0] NOTE_REST = 4'd0;

    // One song entry as latched for playback
    typedef struct packed {
        logic [3:0] note;
        logic [1:0] octave;
        logic [3:0] dur;
    } note_rec_t;

    // Ticks per duration unit for each tempo setting
    function automatic logic [4:0] unit_ticks(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5'd25;
            2'b01:   return 5'd20;
            2'b10:   return 5'd15;
            default: return 5'd10;
        endcase
    endfunction

    // One-hot LED for notes 1..7; rests and codes 8..15 light nothing
    function automatic logic [6:0] note_to_led(input logic [3:0] note);
        case (note)
            4'd1:    return 7'b000_0001;
            4'd2:    return 7'b000_0010;
            4'd3:    return 7'b000_0100;
            4'd4:    return 7'b000_1000;
            4'd5:    return 7'b001_0000;
            4'd6:    return 7'b010_0000;
            4'd7:    return 7'b100_0000;
            default: return 7'b000_0000;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Divides the system clock down to the tempo tick. Counts only while
// run is high and can be restarted from zero with clear.
`timescale 1ns/1ps
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Free-running divider, restarted on clear, frozen when not running
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with <= so every flop
        // samples the pre-edge value of its inputs.
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = run && (cnt_q == CNT_MAX);

endmodule

// File: rtl/auto_play_sequencer.sv
// Auto-play scheduler: walks the song ROM entry by entry, times each note
// from the tempo tick, and drives the buzzer, LED and display indices.
`timescale 1ns/1ps
module auto_play_sequencer
    import piano_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int SONG_LEN  = 64,
    parameter int GAP_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start_pulse,
    input  logic       next_pulse,
    input  logic       prev_pulse,
    input  logic [1:0] speed_sel,
    output logic [7:0] rom_addr,
    input  logic [9:0] rom_data,
    output logic [3:0] note_out,
    output logic [1:0] octave_out,
    output logic [6:0] led_out,
    output logic [5:0] note_idx,
    output logic [1:0] song_idx,
    output logic       playing,
    output logic       done_pulse
);

    localparam logic [5:0] LAST_IDX  = 6'(SONG_LEN - 1);
    localparam logic [8:0] GAP_LIMIT = 9'(GAP_TICKS);

    logic [2:0] state_q, state_d;
    logic [1:0] song_q,  song_d;
    logic [5:0] idx_q,   idx_d;
    note_rec_t  cur_q,   cur_d;
    logic [4:0] unit_q,  unit_d;
    logic [8:0] tcnt_q,  tcnt_d;

    logic       tick;
    logic       clr_tick;
    logic       run_tick;
    logic       to_idle;
    logic       song_evt;
    logic [8:0] tcnt_inc;
    logic [8:0] play_ticks;
    note_rec_t  rom_rec;

    assign rom_rec    = '{note:   rom_data[NOTE_MSB -: 4],
                          octave: rom_data[OCT_MSB -: 2],
                          dur:    rom_data[DUR_MSB -: 4]};
    assign song_evt   = next_pulse ^ prev_pulse;
    assign run_tick   = (state_q == ST_PLAY) || (state_q == ST_GAP);
    assign tcnt_inc   = tcnt_q + 9'd1;
    assign play_ticks = 9'(cur_q.dur) * 9'(unit_q);

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (clr_tick),
        .run   (run_tick),
        .tick  (tick)
    );

    // Next-state logic: user overrides first, then the note sequencing FSM
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves one unassigned and infers a latch.
        state_d  = state_q;
        song_d   = song_q;
        idx_d    = idx_q;
        cur_d    = cur_q;
        unit_d   = unit_q;
        tcnt_d   = tick ? tcnt_inc : tcnt_q;
        clr_tick = 1'b0;
        to_idle  = 1'b0;

        if (song_evt) begin
            // Song change beats any start request in the same cycle
            song_d  = next_pulse ? song_q + 2'd1 : song_q - 2'd1;
            to_idle = 1'b1;
        end else if (!enable) begin
            to_idle = 1'b1;
        end else if (start_pulse && playing) begin
            to_idle = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state_d = ST_FETCH;
                        idx_d   = '0;
                    end
                end
                ST_FETCH: state_d = ST_LOAD;
                ST_LOAD: begin
                    if (rom_rec.dur == 4'd0) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        cur_d   = '0;
                    end else begin
                        state_d  = ST_PLAY;
                        cur_d    = rom_rec;
                        unit_d   = unit_ticks(speed_sel);
                        tcnt_d   = '0;
                        clr_tick = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (tick && (tcnt_inc >= play_ticks)) begin
                        state_d    = ST_GAP;
                        cur_d.note = NOTE_REST;
                        tcnt_d     = '0;
                        clr_tick   = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick && (tcnt_inc >= GAP_LIMIT)) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                            cur_d   = '0;
                        end else begin
                            state_d = ST_FETCH;
                            idx_d   = idx_q + 6'd1;
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        if (to_idle) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cur_d   = '0;
        end
    end

    // State registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            song_q  <= '0;
            idx_q   <= '0;
            cur_q   <= '0;
            unit_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            unit_q  <= unit_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Outputs decode straight from registered state
    assign rom_addr   = {song_q, idx_q};
    assign note_idx   = idx_q;
    assign song_idx   = song_q;
    assign note_out   = (state_q == ST_PLAY) ? cur_q.note : NOTE_REST;
    assign octave_out = run_tick ? cur_q.octave : 2'd0;
    assign led_out    = (state_q == ST_PLAY) ? note_to_led(cur_q.note) : 7'd0;
    assign playing    = (state_q == ST_FETCH) || (state_q == ST_LOAD) || run_tick;
    assign done_pulse = (state_q == ST_DONE);

endmodule
